// File: rtl/cw_sym_collector.sv
// CW symbol collector: assembles dot/dash edges into Morse characters and queues them for a consumer.
// Optional feature macro CW_WORD_SPACE_EN adds word-space entries (explicit input and idle-gap timer).
module cw_sym_collector #(
    parameter int MAX_ELEM   = 6,
    parameter int FIFO_DEPTH = 4,
    parameter int WORD_GAP   = 4096
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                dot_inp,
    input  logic                dash_inp,
    input  logic                char_space_inp,
    input  logic                word_space_inp,
    output logic [MAX_ELEM-1:0] sym_code,
    output logic [2:0]          sym_len,
    output logic                sym_space,
    output logic                sym_err,
    output logic                sym_valid,
    input  logic                sym_ready,
    output logic                ovf,
    input  logic                ovf_clr,
    output logic                busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = MAX_ELEM + 5;
    localparam logic [2:0] LMAX = 3'(MAX_ELEM);

    typedef enum logic { IDLE, COLLECT } state_t;

    // Edge detection: registered rising-edge pulses, one cycle after the input is sampled high.
    logic [2:0] raw, prev, edg;
    assign raw = {char_space_inp, dash_inp, dot_inp};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev <= '0;
            edg  <= '0;
        end else begin
            prev <= raw;
            edg  <= raw & ~prev;
        end
    end

    logic e_dot, e_dash, e_cs, elem, close;
    assign e_dot  = edg[0];
    assign e_dash = edg[1];
    assign e_cs   = edg[2];
    assign elem   = e_dot | e_dash;

`ifdef CW_WORD_SPACE_EN
    localparam int GW = $clog2(WORD_GAP + 1);
    logic          ws_prev, ws_edg;
    logic          armed, gap_run, space_pend;
    logic [GW-1:0] idle_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ws_prev <= 1'b0;
            ws_edg  <= 1'b0;
        end else begin
            ws_prev <= word_space_inp;
            ws_edg  <= word_space_inp & ~ws_prev;
        end
    end
`else
    logic unused_ws;
    localparam int UNUSED_GAP = WORD_GAP;
    assign unused_ws = word_space_inp;
`endif

    state_t                state;
    logic [2:0]            len;
    logic [MAX_ELEM-1:0]   code;
    logic                  err;
    logic                  push;
    logic [EW-1:0]         push_data;

`ifdef CW_WORD_SPACE_EN
    assign close = (state == COLLECT) && (e_cs || ws_edg);
`else
    assign close = (state == COLLECT) && e_cs;
`endif

    // Closing a character happens before any element edge of the same cycle starts the next one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            len       <= '0;
            code      <= '0;
            err       <= 1'b0;
            push      <= 1'b0;
            push_data <= '0;
`ifdef CW_WORD_SPACE_EN
            armed      <= 1'b0;
            gap_run    <= 1'b0;
            space_pend <= 1'b0;
            idle_cnt   <= '0;
`endif
        end else begin
            push <= 1'b0;
            if (close) begin
                push      <= 1'b1;
                push_data <= {err, 1'b0, len, code};
            end
            if (close || state == IDLE) begin
                if (elem) begin
                    state <= COLLECT;
                    len   <= 3'd1;
                    code  <= MAX_ELEM'(e_dash);
                    err   <= 1'b0;
                end else begin
                    state <= IDLE;
                    len   <= '0;
                    code  <= '0;
                    err   <= 1'b0;
                end
            end else if (elem) begin
                if (len < LMAX) begin
                    code <= code | (MAX_ELEM'(e_dash) << len);
                    len  <= len + 3'd1;
                end else begin
                    err <= 1'b1;
                end
            end
`ifdef CW_WORD_SPACE_EN
            if (close) begin
                idle_cnt   <= '0;
                gap_run    <= 1'b1;
                space_pend <= space_pend | ws_edg;
            end else begin
                if (state == IDLE && gap_run && idle_cnt != GW'(WORD_GAP))
                    idle_cnt <= idle_cnt + GW'(1);
                if (space_pend ||
                    (state == IDLE && armed && (ws_edg || idle_cnt == GW'(WORD_GAP)))) begin
                    push       <= 1'b1;
                    push_data  <= {1'b0, 1'b1, 3'd0, {MAX_ELEM{1'b0}}};
                    space_pend <= 1'b0;
                    armed      <= 1'b0;
                end
            end
            // A new element re-arms the generator even if a space leaves this cycle.
            if (elem)
                armed <= 1'b1;
`endif
        end
    end

    assign busy = (len != 3'd0);

    // Show-ahead queue; a push while full only lands if the head leaves in the same cycle.
    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, pop, wr_en, drop;
    logic [EW-1:0] head;

    assign full  = (count == (AW+1)'(FIFO_DEPTH));
    assign pop   = sym_valid & sym_ready;
    assign wr_en = push & (~full | pop);
    assign drop  = push & full & ~pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(wr_en) - (AW+1)'(pop);
            if (drop)
                ovf <= 1'b1;
            else if (ovf_clr)
                ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= push_data;
    end

    assign sym_valid = (count != '0);
    assign head      = sym_valid ? mem[rd_ptr] : '0;
    assign {sym_err, sym_space, sym_len, sym_code} = head;

endmodule
